bus_arbiter8: RTL and testbench

- Round-robin arbiter for an 8-way shared datapath resource, e.g. the writeback or memory-port path fed by the 8-channel multiplexer.
- Accepts requests from up to 8 requesters and grants exactly one at a time.
- Drives the 3-bit mux select for the current owner.
- Holds the grant until the owner finishes, drops its request, or exceeds a hold limit.

---
 rtl/bus_arbiter8_if.sv | 20 ++
 rtl/bus_arbiter8.sv | 102 ++++++++++
 tb/tb_bus_arbiter8.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter8_if.sv
// Request/grant bundle between the arbiter and its eight requesters.
// The arbiter takes the slave side; the requester cluster (or bench) drives the master side.
interface bus_arbiter8_if;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, sel, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, sel, busy, timeout
  );
endinterface

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for an 8-way shared path: one-hot grant plus mux select,
// held until done / request drop / hold limit, always followed by one dead cycle.
module bus_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       owner_done;
  logic       limit_hit;

  // Scan starting at ptr so the last owner is visited last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req  = bus.req[sel_q];
  assign owner_done = bus.done[sel_q];
  assign limit_hit  = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 8'b1 << win_idx;
          sel_d   = win_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (owner_done || !owner_req || limit_hit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = sel_q + 3'd1;
          hold_d    = '0;
          // Pulse only when the hold limit alone forced the release.
          timeout_d = limit_hit && owner_req && !owner_done;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed plus randomized checks of bus_arbiter8 against a cycle-level ownership model.
module tb_bus_arbiter8;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter8_if bus ();

  bus_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner index (-1 = none), cycles owned so far, rotating start point.
  int         m_owner;
  int         m_ptr;
  int         m_held;
  logic [2:0] m_sel;
  logic       m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_sel     = '0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] d);
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (r[c]) begin
          m_owner = c;
          m_sel   = 3'(c);
          m_held  = 1;
          break;
        end
      end
    end else begin
      bit hit;
      hit = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (d[m_owner] || !r[m_owner] || hit) begin
        m_timeout = hit && r[m_owner] && !d[m_owner];
        m_ptr     = (m_owner + 1) % 8;
        m_owner   = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gnt"},     32'(bus.gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".sel"},     32'(bus.sel),     32'(m_sel));
    check({tag, ".busy"},    32'(bus.busy),    32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(m_timeout));
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic [7:0] d);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_model(tag);
  endtask

  // Pulls reset between clock edges and checks the outputs cleared with no edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    bus.req  = '0;
    bus.done = '0;
    reset_n  = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rr;
    logic [7:0] dd;
    bus.req  = '0;
    bus.done = '0;
    model_reset();

    // 1: single requester, done on third grant cycle
    apply_reset("t1.reset");
    cycle("t1.req", 8'h04, 8'h00);
    check("t1.gnt_first", 32'(bus.gnt), 32'h04);
    check("t1.sel_first", 32'(bus.sel), 32'd2);
    cycle("t1.hold", 8'h04, 8'h00);
    cycle("t1.hold", 8'h04, 8'h00);
    cycle("t1.done", 8'h04, 8'h04);
    check("t1.gnt_after_done", 32'(bus.gnt), 32'h00);
    check("t1.timeout", 32'(bus.timeout), 32'd0);
    cycle("t1.idle", 8'h00, 8'h00);

    // 2: all requesting, done on first grant cycle -> strict rotation, one dead cycle
    apply_reset("t2.reset");
    for (int i = 0; i < 9; i++) begin
      cycle("t2.grant", 8'hFF, 8'h00);
      check("t2.order_gnt", 32'(bus.gnt), 32'd1 << (i % 8));
      check("t2.order_sel", 32'(bus.sel), 32'(i % 8));
      cycle("t2.dead", 8'hFF, 8'(1 << (i % 8)));
      check("t2.dead_gnt", 32'(bus.gnt), 32'h00);
    end
    cycle("t2.idle", 8'h00, 8'h00);

    // 3: hold-limit timeout
    cycle("t3.req", 8'h20, 8'h00);
    for (int i = 1; i < MAX_HOLD; i++) begin
      cycle("t3.hold", 8'h20, 8'h00);
      check("t3.hold_gnt", 32'(bus.gnt), 32'h20);
    end
    cycle("t3.expire", 8'h20, 8'h00);
    check("t3.gnt_released", 32'(bus.gnt), 32'h00);
    check("t3.timeout_pulse", 32'(bus.timeout), 32'd1);
    cycle("t3.regrant", 8'h20, 8'h00);
    check("t3.regrant_gnt", 32'(bus.gnt), 32'h20);
    check("t3.timeout_clear", 32'(bus.timeout), 32'd0);
    cycle("t3.drop", 8'h00, 8'h00);

    // 4: owner drops request, waiting requester takes over after a dead cycle
    apply_reset("t4.reset");
    cycle("t4.req3", 8'h08, 8'h00);
    check("t4.gnt3", 32'(bus.gnt), 32'h08);
    cycle("t4.hold", 8'h48, 8'h00);
    cycle("t4.drop3", 8'h40, 8'h00);
    check("t4.gnt_dead", 32'(bus.gnt), 32'h00);
    check("t4.no_timeout", 32'(bus.timeout), 32'd0);
    cycle("t4.grant6", 8'h40, 8'h00);
    check("t4.gnt6", 32'(bus.gnt), 32'h40);
    check("t4.sel6", 32'(bus.sel), 32'd6);
    cycle("t4.idle", 8'h00, 8'h00);

    // 5: done coincides with hold limit -> no timeout, pointer advances to 2
    apply_reset("t5.reset");
    cycle("t5.req1", 8'h02, 8'h00);
    for (int i = 1; i < MAX_HOLD; i++) cycle("t5.hold", 8'h02, 8'h00);
    cycle("t5.done_at_limit", 8'h02, 8'h02);
    check("t5.gnt_released", 32'(bus.gnt), 32'h00);
    check("t5.timeout", 32'(bus.timeout), 32'd0);
    cycle("t5.ptr", 8'h07, 8'h00);
    check("t5.ptr_gnt", 32'(bus.gnt), 32'h04);
    cycle("t5.idle", 8'h00, 8'h00);

    // 6: async reset during grant, then pointer back at 0
    apply_reset("t6.reset");
    cycle("t6.req4", 8'h10, 8'h00);
    check("t6.gnt4", 32'(bus.gnt), 32'h10);
    cycle("t6.hold", 8'h10, 8'h00);
    apply_reset("t6.async");
    check("t6.async_gnt", 32'(bus.gnt), 32'h00);
    check("t6.async_busy", 32'(bus.busy), 32'd0);
    cycle("t6.req11", 8'h11, 8'h00);
    check("t6.gnt0", 32'(bus.gnt), 32'h01);
    cycle("t6.idle", 8'h00, 8'h00);

    // Random traffic: slowly changing request set, sparse done strobes
    rr = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) rr = 8'($urandom);
      dd = ($urandom_range(0, 6) == 0) ? 8'($urandom) : 8'h00;
      cycle("rand", rr, dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
